// File: rtl/io_ring_sequencer.sv
// io_ring_sequencer: ramps IO pad-group output enables up and down one group per slot.
// Ports:
//   clk, rst_b          clock, asynchronous active-low reset
//   start, shutdown     level-sampled ramp-up / ramp-down requests (shutdown wins)
//   group_mask, dwell   participating groups and extra settle cycles, latched on start
//   pad_oe              registered per-group pad output enables
//   busy, done, state   ramp in progress, ramp-up complete, encoded FSM state
module io_ring_sequencer #(
    parameter int N_GRP = 8,
    parameter int DW    = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             shutdown,
    input  logic [N_GRP-1:0] group_mask,
    input  logic [DW-1:0]    dwell,
    output logic [N_GRP-1:0] pad_oe,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);
    localparam int IW = $clog2(N_GRP);
    localparam logic [IW-1:0] LAST = IW'(N_GRP - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RAMP_UP = 2'd1, ON = 2'd2, RAMP_DOWN = 2'd3} st_t;

    st_t cur, nxt_st;
    logic [IW-1:0] idx, nidx;
    logic [DW-1:0] cnt, dwell_q;
    logic [N_GRP-1:0] mask_q;
    logic act, up, fin, sw;

    // act is clear only on the edge that opens the first slot of a ramp; afterwards
    // every edge with cnt==0 both closes the current slot and opens the next one.
    always_comb begin
        up   = cur == RAMP_UP;
        fin  = act && cnt == '0 && idx == (up ? LAST : '0);
        nidx = act ? (up ? idx + IW'(1) : idx - IW'(1)) : idx;
        sw   = up ? mask_q[nidx] : pad_oe[nidx];
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) cur <= IDLE;
        else        cur <= nxt_st;
    end

    always_comb begin
        nxt_st = cur;
        case (cur)
            IDLE:      nxt_st = (start && !shutdown) ? RAMP_UP : IDLE;
            RAMP_UP:   nxt_st = shutdown ? RAMP_DOWN : (fin ? ON : RAMP_UP);
            ON:        nxt_st = shutdown ? RAMP_DOWN : ON;
            RAMP_DOWN: nxt_st = fin ? IDLE : RAMP_DOWN;
            default:   nxt_st = IDLE;
        endcase
    end

    always_comb begin
        busy  = cur == RAMP_UP || cur == RAMP_DOWN;
        done  = cur == ON;
        state = cur;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pad_oe  <= '0;
            idx     <= '0;
            cnt     <= '0;
            act     <= 1'b0;
            mask_q  <= '0;
            dwell_q <= '0;
        end else if (nxt_st != cur) begin
            act <= 1'b0;
            cnt <= '0;
            idx <= nxt_st == RAMP_DOWN ? LAST : '0;
            if (cur == IDLE) begin
                mask_q  <= group_mask;
                dwell_q <= dwell;
            end
        end else if (busy) begin
            if (!act || cnt == '0) begin
                // slot start: only this group's enable may change on this edge
                idx          <= nidx;
                pad_oe[nidx] <= up & mask_q[nidx];
                cnt          <= sw ? dwell_q : '0;
                act          <= 1'b1;
            end else begin
                cnt <= cnt - DW'(1);
            end
        end
    end
endmodule
